// File: rtl/usr_counter_pkg.sv
// rtl/usr_counter_pkg.sv - command/state types and widths for the user counter sequencer
package usr_counter_pkg;

    localparam int PRESCALE_W = 8;

    typedef enum logic [1:0] {
        CNT_OP_START  = 2'd0,
        CNT_OP_STOP   = 2'd1,
        CNT_OP_RESUME = 2'd2,
        CNT_OP_CLEAR  = 2'd3
    } usr_cnt_op_t;

    typedef enum logic [1:0] {
        CNT_IDLE  = 2'd0,
        CNT_RUN   = 2'd1,
        CNT_PAUSE = 2'd2,
        CNT_DONE  = 2'd3
    } usr_cnt_state_t;

endpackage

// File: rtl/usr_counter_ctrl_if.sv
// rtl/usr_counter_ctrl_if.sv - valid/ready command port of the user counter sequencer
interface usr_counter_ctrl_if #(
    parameter int CNT_W = 4
);
    import usr_counter_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    usr_cnt_op_t      cmd_op;
    logic [CNT_W-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/usr_counter_step.sv
// rtl/usr_counter_step.sv - prescaler, limit compare and wrapping count (USR_CNT_PRESCALE_EN adds prescaler)
module usr_counter_step
    import usr_counter_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic                  usr_clk,
    input  logic                  usr_rst,
    input  logic                  run,
    input  logic                  start,
    input  logic                  clear,
    input  logic [CNT_W-1:0]      limit_in,
`ifdef USR_CNT_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [CNT_W-1:0]      count,
    output logic                  step_tc
);

    logic [CNT_W-1:0] limit_q;
    logic [CNT_W-1:0] count_q;
    logic             step;

`ifdef USR_CNT_PRESCALE_EN
    logic [PRESCALE_W-1:0] pre_q;

    // prescale is compared live, so a new value takes effect on the next cycle
    assign step = run && (pre_q == prescale);

    always_ff @(posedge usr_clk) begin
        if (usr_rst) begin
            pre_q <= '0;
        end else if (start || clear) begin
            pre_q <= '0;
        end else if (run) begin
            pre_q <= step ? '0 : pre_q + 1'b1;
        end
    end
`else
    assign step = run;
`endif

    assign step_tc = step && (count_q == limit_q);
    assign count   = count_q;

    // wrap at the limit is explicit, so limit = all-ones never relies on overflow
    always_ff @(posedge usr_clk) begin
        if (usr_rst) begin
            count_q <= '0;
            limit_q <= '0;
        end else begin
            if (start) begin
                limit_q <= limit_in;
            end
            if (start || clear) begin
                count_q <= '0;
            end else if (step) begin
                count_q <= step_tc ? '0 : count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/usr_counter_ctrl.sv
// rtl/usr_counter_ctrl.sv - command FSM for the user counter (optional USR_CNT_PRESCALE_EN prescaler)
module usr_counter_ctrl
    import usr_counter_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                  usr_clk,
    input  logic                  usr_rst,
    usr_counter_ctrl_if.slave     cmd,
`ifdef USR_CNT_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] i_prescale,
`endif
    output logic [CNT_W-1:0]      o_count,
    output usr_cnt_state_t        o_state,
    output logic                  o_busy,
    output logic                  o_tc
);

    usr_cnt_state_t state_q;
    usr_cnt_state_t state_d;
    logic           tc_d;
    logic           accept;
    logic           do_start;
    logic           do_clear;
    logic           step_tc;

    assign cmd.cmd_ready = ~usr_rst;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign do_start      = accept && (cmd.cmd_op == CNT_OP_START);
    assign do_clear      = accept && (cmd.cmd_op == CNT_OP_CLEAR);

    usr_counter_step #(
        .CNT_W (CNT_W)
    ) u_step (
        .usr_clk  (usr_clk),
        .usr_rst  (usr_rst),
        .run      (state_q == CNT_RUN),
        .start    (do_start),
        .clear    (do_clear),
        .limit_in (cmd.cmd_data),
`ifdef USR_CNT_PRESCALE_EN
        .prescale (i_prescale),
`endif
        .count    (o_count),
        .step_tc  (step_tc)
    );

    always_ff @(posedge usr_clk) begin
        if (usr_rst) begin
            state_q <= CNT_IDLE;
            o_tc    <= 1'b0;
        end else begin
            state_q <= state_d;
            o_tc    <= tc_d;
        end
    end

    // an accepted command overrides the terminal-count transition
    always_comb begin
        state_d = state_q;
        tc_d    = step_tc && !do_start && !do_clear;
        if (step_tc && !AUTO_RELOAD) begin
            state_d = CNT_DONE;
        end
        if (accept) begin
            case (cmd.cmd_op)
                CNT_OP_START:  state_d = CNT_RUN;
                CNT_OP_STOP:   if (state_q == CNT_RUN) state_d = CNT_PAUSE;
                CNT_OP_RESUME: if (state_q == CNT_PAUSE) state_d = CNT_RUN;
                CNT_OP_CLEAR:  state_d = CNT_IDLE;
                default:       state_d = state_q;
            endcase
        end
    end

    assign o_state = state_q;
    assign o_busy  = (state_q == CNT_RUN) || (state_q == CNT_PAUSE);

endmodule

// File: tb/tb_usr_counter_ctrl.sv
// tb/tb_usr_counter_ctrl.sv - bench for usr_counter_ctrl, one-shot and auto-reload instances side by side
module tb_usr_counter_ctrl;
    import usr_counter_pkg::*;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             usr_clk = 1'b0;
    logic             usr_rst = 1'b1;
    logic             cv      = 1'b0;
    usr_cnt_op_t      cop     = CNT_OP_START;
    logic [CNT_W-1:0] cdata   = '0;
    logic [7:0]       psc     = 8'd0;

    logic [CNT_W-1:0] o_count [2];
    usr_cnt_state_t   o_state [2];
    logic             o_busy  [2];
    logic             o_tc    [2];

    int tests = 0;
    int fails = 0;

    int m_cnt [2];
    int m_st  [2];
    int m_lim [2];
    int m_pre [2];
    int m_tc  [2];

    always #5 usr_clk = ~usr_clk;

    usr_counter_ctrl_if #(.CNT_W(CNT_W)) cif0 ();
    usr_counter_ctrl_if #(.CNT_W(CNT_W)) cif1 ();

    assign cif0.cmd_valid = cv;
    assign cif0.cmd_op    = cop;
    assign cif0.cmd_data  = cdata;
    assign cif1.cmd_valid = cv;
    assign cif1.cmd_op    = cop;
    assign cif1.cmd_data  = cdata;

    usr_counter_ctrl #(.CNT_W(CNT_W), .AUTO_RELOAD(1'b0)) dut0 (
        .usr_clk    (usr_clk),
        .usr_rst    (usr_rst),
        .cmd        (cif0.slave),
`ifdef USR_CNT_PRESCALE_EN
        .i_prescale (psc),
`endif
        .o_count    (o_count[0]),
        .o_state    (o_state[0]),
        .o_busy     (o_busy[0]),
        .o_tc       (o_tc[0])
    );

    usr_counter_ctrl #(.CNT_W(CNT_W), .AUTO_RELOAD(1'b1)) dut1 (
        .usr_clk    (usr_clk),
        .usr_rst    (usr_rst),
        .cmd        (cif1.slave),
`ifdef USR_CNT_PRESCALE_EN
        .i_prescale (psc),
`endif
        .o_count    (o_count[1]),
        .o_state    (o_state[1]),
        .o_busy     (o_busy[1]),
        .o_tc       (o_tc[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: state codes 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE; instance i auto-reloads when i==1.
    task automatic model_edge();
        int eff_psc;
`ifdef USR_CNT_PRESCALE_EN
        eff_psc = psc;
`else
        eff_psc = 0;
`endif
        for (int i = 0; i < 2; i++) begin
            if (usr_rst) begin
                m_cnt[i] = 0; m_st[i] = 0; m_lim[i] = 0; m_pre[i] = 0; m_tc[i] = 0;
            end else begin
                int ncnt, nst, npre, ntc;
                ncnt = m_cnt[i]; nst = m_st[i]; npre = m_pre[i]; ntc = 0;
                if (m_st[i] == 1) begin
                    if (m_pre[i] == eff_psc) begin
                        npre = 0;
                        if (m_cnt[i] == m_lim[i]) begin
                            ncnt = 0;
                            ntc  = 1;
                            nst  = (i == 1) ? 1 : 3;
                        end else begin
                            ncnt = (m_cnt[i] + 1) % (CMAX + 1);
                        end
                    end else begin
                        npre = m_pre[i] + 1;
                    end
                end
                if (cv) begin
                    case (int'(cop))
                        0: begin m_lim[i] = cdata; ncnt = 0; nst = 1; npre = 0; ntc = 0; end
                        1: if (m_st[i] == 1) nst = 2;
                        2: if (m_st[i] == 2) nst = 1;
                        default: begin ncnt = 0; nst = 0; npre = 0; ntc = 0; end
                    endcase
                end
                m_cnt[i] = ncnt; m_st[i] = nst; m_pre[i] = npre; m_tc[i] = ntc;
            end
        end
    endtask

    task automatic tick();
        logic rdy_exp;
        rdy_exp = ~usr_rst;
        model_edge();
        @(posedge usr_clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("count%0d", i), 32'(o_count[i]), 32'(m_cnt[i]));
            chk($sformatf("state%0d", i), 32'(o_state[i]), 32'(m_st[i]));
            chk($sformatf("tc%0d", i), 32'(o_tc[i]), 32'(m_tc[i]));
            chk($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(m_st[i] == 1 || m_st[i] == 2));
        end
        chk("ready0", 32'(cif0.cmd_ready), 32'(rdy_exp));
        chk("ready1", 32'(cif1.cmd_ready), 32'(rdy_exp));
    endtask

    task automatic send(input usr_cnt_op_t op, input int data);
        cv = 1'b1; cop = op; cdata = CNT_W'(data);
        tick();
        cv = 1'b0;
    endtask

    initial begin
        int ntc;
        int seq [5];
        seq = '{0, 1, 2, 3, 0};

        // reset state
        tick();
        tick();
        chk("rst_count", 32'(o_count[0]), 0);
        chk("rst_state", 32'(o_state[0]), 32'(CNT_IDLE));
        chk("rst_ready", 32'(cif0.cmd_ready), 0);
        usr_rst = 1'b0;
        tick();

        // one-shot limit 3
        send(CNT_OP_START, 3);
        chk("ls3_c0", 32'(o_count[0]), 32'(seq[0]));
        for (int k = 1; k < 5; k++) begin
            tick();
            chk($sformatf("ls3_c%0d", k), 32'(o_count[0]), 32'(seq[k]));
        end
        chk("ls3_tc", 32'(o_tc[0]), 1);
        chk("ls3_done", 32'(o_state[0]), 32'(CNT_DONE));
        chk("ls3_ar_run", 32'(o_state[1]), 32'(CNT_RUN));
        tick();
        chk("ls3_tc_once", 32'(o_tc[0]), 0);

        // auto-reload limit 2: tc every third step
        send(CNT_OP_START, 2);
        ntc = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            ntc += int'(o_tc[1]);
        end
        chk("ar_tc_count", 32'(ntc), 3);
        chk("ar_state", 32'(o_state[1]), 32'(CNT_RUN));

        // pause and resume, limit 7
        send(CNT_OP_START, 7);
        repeat (3) tick();
        send(CNT_OP_STOP, 0);
        repeat (5) tick();
        chk("pause_hold", 32'(o_count[0]), 4);
        chk("pause_state", 32'(o_state[0]), 32'(CNT_PAUSE));
        send(CNT_OP_RESUME, 0);
        chk("resume_cnt", 32'(o_count[0]), 4);
        repeat (4) tick();
        chk("resume_tc", 32'(o_tc[0]), 1);
        chk("resume_done", 32'(o_state[0]), 32'(CNT_DONE));

        // STOP and CLEAR colliding with terminal count, limit 1
        send(CNT_OP_START, 1);
        tick();
        send(CNT_OP_STOP, 0);
        chk("stoptc_state", 32'(o_state[0]), 32'(CNT_PAUSE));
        chk("stoptc_cnt", 32'(o_count[0]), 0);
        chk("stoptc_tc", 32'(o_tc[0]), 1);
        send(CNT_OP_RESUME, 0);
        tick();
        send(CNT_OP_CLEAR, 0);
        chk("clrtc_state", 32'(o_state[0]), 32'(CNT_IDLE));
        chk("clrtc_tc", 32'(o_tc[0]), 0);

        // reset mid-run with a command pending
        send(CNT_OP_START, 9);
        repeat (5) tick();
        chk("prerst_cnt", 32'(o_count[0]), 5);
        usr_rst = 1'b1; cv = 1'b1; cop = CNT_OP_START; cdata = 4'd3;
        tick();
        chk("midrst_cnt", 32'(o_count[0]), 0);
        chk("midrst_state", 32'(o_state[0]), 32'(CNT_IDLE));
        chk("midrst_ready", 32'(cif0.cmd_ready), 0);
        usr_rst = 1'b0; cv = 1'b0;
        tick();

        // full-range limit
        send(CNT_OP_START, CMAX);
        repeat (CMAX + 3) tick();

`ifdef USR_CNT_PRESCALE_EN
        psc = 8'd2;
        send(CNT_OP_START, 1);
        repeat (6) tick();
        chk("psc_tc", 32'(o_tc[0]), 1);
        chk("psc_done", 32'(o_state[0]), 32'(CNT_DONE));
        psc = 8'd0;
`endif

        // randomized commands, prescale and resets
        for (int n = 0; n < 400; n++) begin
            usr_rst = ($urandom_range(0, 63) == 0);
            cv      = ($urandom_range(0, 3) == 0);
            cop     = usr_cnt_op_t'($urandom_range(0, 3));
            cdata   = CNT_W'($urandom);
            psc     = 8'($urandom_range(0, 3));
            tick();
        end
        usr_rst = 1'b0;
        cv      = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
